// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable serial pattern detector.
// Bits are accepted only when in_valid is high. When the newest accepted bits
// equal the loaded pattern, the registered flag z goes high. Detection can be
// overlapping or non-overlapping, and a saturating counter records matches.
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic               z_q;
    logic [CNT_W-1:0]   count_q;
    logic               err_q;

    logic               accept;
    logic               match;
    logic               len_bad;
    logic [MAX_LEN-1:0] mask;

    // Next history/fill for an accepted bit, the compare mask and the match decision
    always_comb begin
        accept  = in_valid && !cfg_load;
        hist_d  = {hist_q[MAX_LEN-2:0], x};
        fill_d  = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        len_bad = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
        mask    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        match = accept && !err_q && (fill_d >= len_q) &&
                ((hist_d & mask) == (pat_q & mask));
    end

    // All detector state: configuration, history, detect flag and match counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= MAX_LEN'(5);
            len_q   <= LEN_W'(3);
            ovl_q   <= 1'b1;
            z_q     <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (cfg_load) begin
                pat_q  <= cfg_pattern;
                len_q  <= cfg_len;
                ovl_q  <= cfg_overlap;
                err_q  <= len_bad;
                hist_q <= '0;
                fill_q <= '0;
                z_q    <= 1'b0;
            end else if (accept) begin
                hist_q <= hist_d;
                z_q    <= match;
                if (match && !ovl_q) begin
                    fill_q <= '0;
                end else begin
                    fill_q <= fill_d;
                end
            end

            if (count_clr) begin
                count_q <= match ? CNT_W'(1) : '0;
            end else if (match && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign z           = z_q;
    assign match_count = count_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the detector.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       xIn = 1'b0;
    logic       inValid = 1'b0;
    logic       cfgLoad = 1'b0;
    logic [7:0] cfgPattern = '0;
    logic [3:0] cfgLen = '0;
    logic       cfgOverlap = 1'b0;
    logic       countClr = 1'b0;

    logic       zBig, errBig, zSmall, errSmall;
    logic [7:0] cntBig;
    logic [1:0] cntSmall;

    int total = 0;
    int bad = 0;

    // model state
    int   hq[$];
    int   mPat, mLen, mOvl, mErr, mZ, mCntBig, mCntSmall;

    always #5 clk = ~clk;

    seq_detect_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .x(xIn), .in_valid(inValid), .cfg_load(cfgLoad),
        .cfg_pattern(cfgPattern), .cfg_len(cfgLen), .cfg_overlap(cfgOverlap),
        .count_clr(countClr), .z(zBig), .match_count(cntBig), .cfg_err(errBig)
    );

    seq_detect_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dutSmall (
        .clk(clk), .rst(rst), .x(xIn), .in_valid(inValid), .cfg_load(cfgLoad),
        .cfg_pattern(cfgPattern), .cfg_len(cfgLen), .cfg_overlap(cfgOverlap),
        .count_clr(countClr), .z(zSmall), .match_count(cntSmall), .cfg_err(errSmall)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d exp=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        hq.delete();
        mPat = 5; mLen = 3; mOvl = 1; mErr = 0; mZ = 0;
        mCntBig = 0; mCntSmall = 0;
    endtask

    function automatic bit tailMatches();
        for (int k = 0; k < mLen; k++) begin
            if (hq[hq.size() - 1 - k] != ((mPat >> k) & 1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelStep(input int xv, vld, load, pat, len, ovl, clr);
        bit m;
        m = 1'b0;
        if (load) begin
            mPat = pat; mLen = len; mOvl = ovl;
            mErr = (len == 0 || len > 8) ? 1 : 0;
            hq.delete();
            mZ = 0;
        end else if (vld) begin
            hq.push_back(xv);
            if (hq.size() > 8) void'(hq.pop_front());
            m = (mErr == 0) && (hq.size() >= mLen) && tailMatches();
            mZ = m;
            if (m && mOvl == 0) hq.delete();
        end
        if (clr) begin
            mCntBig = m ? 1 : 0;
            mCntSmall = m ? 1 : 0;
        end else if (m) begin
            if (mCntBig < 255) mCntBig++;
            if (mCntSmall < 3) mCntSmall++;
        end
    endtask

    task automatic checkOutput();
        check("z", int'(zBig), mZ);
        check("match_count", int'(cntBig), mCntBig);
        check("cfg_err", int'(errBig), mErr);
        check("z_small", int'(zSmall), mZ);
        check("match_count_small", int'(cntSmall), mCntSmall);
        check("cfg_err_small", int'(errSmall), mErr);
    endtask

    // One clock cycle: drive at the falling edge, model the rising edge, check at the next falling edge
    task automatic applyStimulus(input logic xv, vld, load, input logic [7:0] pat,
                                 input logic [3:0] len, input logic ovl, clr);
        xIn = xv; inValid = vld; cfgLoad = load; cfgPattern = pat;
        cfgLen = len; cfgOverlap = ovl; countClr = clr;
        @(posedge clk);
        modelStep(int'(xv), int'(vld), int'(load), int'(pat), int'(len), int'(ovl), int'(clr));
        @(negedge clk);
        checkOutput();
    endtask

    task automatic bitIn(input logic xv);
        applyStimulus(xv, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic loadCfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                           input logic clr);
        applyStimulus(1'b1, 1'b1, 1'b1, pat, len, ovl, clr);
    endtask

    // Asynchronous reset pulse raised between clock edges
    task automatic pulseReset();
        xIn = 1'b0; inValid = 1'b0; cfgLoad = 1'b0; countClr = 1'b0;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int stream1[7];
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput();
        check("reset z", int'(zBig), 0);
        check("reset count", int'(cntBig), 0);
        check("reset err", int'(errBig), 0);
        rst = 1'b0;

        // default 101 overlapping
        bitIn(1); bitIn(0); bitIn(1);
        check("default z after bit3", int'(zBig), 1);
        bitIn(0);
        check("default z after bit4", int'(zBig), 0);
        bitIn(1);
        check("default z after bit5", int'(zBig), 1);
        check("default count", int'(cntBig), 2);
        check("model default count", mCntBig, 2);

        // 1011 non-overlapping then overlapping
        stream1 = '{1, 0, 1, 1, 0, 1, 1};
        loadCfg(8'b1011, 4'd4, 1'b0, 1'b1);
        foreach (stream1[i]) begin
            bitIn(stream1[i][0]);
            if (i == 3) check("nonovl z after bit4", int'(zBig), 1);
        end
        check("nonovl z after bit7", int'(zBig), 0);
        check("nonovl count", int'(cntBig), 1);
        check("model nonovl count", mCntBig, 1);
        loadCfg(8'b1011, 4'd4, 1'b1, 1'b1);
        foreach (stream1[i]) bitIn(stream1[i][0]);
        check("ovl z after bit7", int'(zBig), 1);
        check("ovl count", int'(cntBig), 2);

        // in_valid gaps with default pattern
        pulseReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        check("gap z after 5th", int'(zBig), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        check("gap z held", int'(zBig), 1);

        // illegal length, then len=1
        loadCfg(8'h01, 4'd0, 1'b1, 1'b0);
        bitIn(1); bitIn(1); bitIn(1);
        check("err flag", int'(errBig), 1);
        check("err z", int'(zBig), 0);
        check("err count unchanged", int'(cntBig), 1);
        loadCfg(8'h01, 4'd1, 1'b0, 1'b0);
        check("err cleared", int'(errBig), 0);
        bitIn(1);
        check("len1 z after 1", int'(zBig), 1);
        bitIn(0);
        check("len1 z after 0", int'(zBig), 0);
        bitIn(1);
        check("len1 z after 1b", int'(zBig), 1);

        // small counter saturation and clear-with-match
        repeat (5) bitIn(1);
        check("small saturated", int'(cntSmall), 3);
        check("model small saturated", mCntSmall, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
        check("clear with match", int'(cntSmall), 1);
        check("clear with match big", int'(cntBig), 1);

        // reset mid-pattern
        pulseReset();
        bitIn(1); bitIn(0);
        pulseReset();
        bitIn(1);
        check("mid reset z", int'(zBig), 0);
        check("mid reset count", int'(cntBig), 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic       rv, rl, ro, rc;
            logic [7:0] rp;
            logic [3:0] rlen;
            if ($urandom_range(0, 299) == 0) begin
                pulseReset();
            end else begin
                rv = ($urandom_range(0, 3) != 0);
                rl = ($urandom_range(0, 39) == 0);
                rc = ($urandom_range(0, 49) == 0);
                ro = 1'($urandom_range(0, 1));
                rp = 8'($urandom);
                if ($urandom_range(0, 9) == 0) rlen = 4'($urandom_range(0, 12));
                else rlen = 4'($urandom_range(1, 4));
                applyStimulus(1'($urandom_range(0, 1)), rv, rl, rp, rlen, ro, rc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
